i2c_target_sync: RTL and testbench

//  Fully synchronous I2C target (slave): the responder end for i2c_master. SCL/SDA are

---
 rtl/i2c_target_sync.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_i2c_target_sync.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_sync.sv
// i2c_target_sync: I2C target oversampled in the clk domain. Matches a 7-bit address,
// receives/transmits bytes with ACK, and stretches SCL while waiting for read data.
module i2c_target_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int SETUP_CYC   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] addr,
  output logic       busy,
  output logic       addressed,
  output logic       read_nwrite,
  output logic [7:0] data_o,
  output logic       data_available,
  output logic       data_request,
  input  logic [7:0] data_i,
  input  logic       data_valid,
  output logic       master_nack,
  inout  wire        SCL,
  inout  wire        SDA
);

  localparam int SW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
  localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYC - 1);
  localparam logic [SW-1:0] SETUP_ONE  = SW'(1);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_WRITE     = 4'd3,
    ST_WRITE_ACK = 4'd4,
    ST_READ_LOAD = 4'd5,
    ST_READ      = 4'd6,
    ST_READ_ACK  = 4'd7,
    ST_WAIT_STOP = 4'd8
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
  logic scl_prev_r, sda_prev_r;
  logic scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s, byte_end_s;

  state_t    state_r, state_nxt_s;
  logic [2:0] bit_cnt_r, bit_cnt_nxt_s;
  logic      byte_full_r, byte_full_nxt_s;
  logic [7:0] shift_r, shift_nxt_s;
  logic      sda_low_r, sda_low_nxt_s;
  logic      scl_low_r, scl_low_nxt_s;
  logic [SW-1:0] setup_cnt_r, setup_cnt_nxt_s;
  logic      busy_r, addressed_r, addressed_nxt_s, rnw_r, rnw_nxt_s;
  logic [7:0] data_o_r, data_o_nxt_s;
  logic      dav_r, dav_nxt_s, dreq_r, dreq_nxt_s, nack_r, nack_nxt_s;

  // Pin synchronisers plus last-sample registers for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], SCL};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], SDA};
      scl_prev_r <= scl_s;
      sda_prev_r <= sda_s;
    end
  end

  assign scl_s      = scl_sync_r[SYNC_STAGES-1];
  assign sda_s      = sda_sync_r[SYNC_STAGES-1];
  assign scl_rise_s = scl_s & ~scl_prev_r;
  assign scl_fall_s = ~scl_s & scl_prev_r;
  assign start_s    = scl_s & sda_prev_r & ~sda_s;
  assign stop_s     = scl_s & ~sda_prev_r & sda_s;
  // byte_full marks that the 8th rise has been seen, since the wrapped counter alone is ambiguous
  assign byte_end_s = scl_fall_s & byte_full_r;

  // Next-state and next-output logic; bus conditions override every state
  always_comb begin
    state_nxt_s     = state_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    byte_full_nxt_s = byte_full_r;
    shift_nxt_s     = shift_r;
    sda_low_nxt_s   = sda_low_r;
    scl_low_nxt_s   = scl_low_r;
    setup_cnt_nxt_s = setup_cnt_r;
    addressed_nxt_s = addressed_r;
    rnw_nxt_s       = rnw_r;
    data_o_nxt_s    = data_o_r;
    dreq_nxt_s      = dreq_r;
    dav_nxt_s       = 1'b0;
    nack_nxt_s      = 1'b0;
    if (stop_s) begin
      state_nxt_s     = ST_IDLE;
      sda_low_nxt_s   = 1'b0;
      scl_low_nxt_s   = 1'b0;
      dreq_nxt_s      = 1'b0;
      addressed_nxt_s = 1'b0;
    end else if (start_s) begin
      state_nxt_s     = ST_ADDR;
      bit_cnt_nxt_s   = 3'd0;
      byte_full_nxt_s = 1'b0;
      sda_low_nxt_s   = 1'b0;
      scl_low_nxt_s   = 1'b0;
      dreq_nxt_s      = 1'b0;
      addressed_nxt_s = 1'b0;
    end else begin
      if (scl_rise_s && (state_r == ST_ADDR || state_r == ST_WRITE || state_r == ST_READ)) begin
        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
        if (bit_cnt_r == 3'd7) begin
          byte_full_nxt_s = 1'b1;
        end else begin
          byte_full_nxt_s = byte_full_r;
        end
        if (state_r != ST_READ) begin
          shift_nxt_s = {shift_r[6:0], sda_s};
        end else begin
          shift_nxt_s = shift_r;
        end
      end else begin
        bit_cnt_nxt_s = bit_cnt_r;
      end
      case (state_r)
        ST_IDLE: begin
          sda_low_nxt_s = 1'b0;
          scl_low_nxt_s = 1'b0;
        end
        ST_ADDR: begin
          if (byte_end_s) begin
            byte_full_nxt_s = 1'b0;
            if (shift_r[7:1] == addr) begin
              state_nxt_s     = ST_ADDR_ACK;
              sda_low_nxt_s   = 1'b1;
              rnw_nxt_s       = shift_r[0];
              addressed_nxt_s = 1'b1;
            end else begin
              state_nxt_s = ST_WAIT_STOP;
            end
          end else begin
            state_nxt_s = ST_ADDR;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall_s) begin
            sda_low_nxt_s = 1'b0;
            if (rnw_r) begin
              state_nxt_s   = ST_READ_LOAD;
              scl_low_nxt_s = 1'b1;
              dreq_nxt_s    = 1'b1;
            end else begin
              state_nxt_s = ST_WRITE;
            end
          end else begin
            state_nxt_s = ST_ADDR_ACK;
          end
        end
        ST_WRITE: begin
          if (byte_end_s) begin
            byte_full_nxt_s = 1'b0;
            data_o_nxt_s    = shift_r;
            dav_nxt_s       = 1'b1;
            sda_low_nxt_s   = 1'b1;
            state_nxt_s     = ST_WRITE_ACK;
          end else begin
            state_nxt_s = ST_WRITE;
          end
        end
        ST_WRITE_ACK: begin
          if (scl_fall_s) begin
            sda_low_nxt_s = 1'b0;
            state_nxt_s   = ST_WRITE;
          end else begin
            state_nxt_s = ST_WRITE_ACK;
          end
        end
        ST_READ_LOAD: begin
          if (dreq_r) begin
            if (data_valid) begin
              dreq_nxt_s      = 1'b0;
              shift_nxt_s     = data_i;
              sda_low_nxt_s   = ~data_i[7];
              setup_cnt_nxt_s = {SW{1'b0}};
              bit_cnt_nxt_s   = 3'd0;
              byte_full_nxt_s = 1'b0;
            end else begin
              state_nxt_s = ST_READ_LOAD;
            end
          end else if (setup_cnt_r == SETUP_LAST) begin
            scl_low_nxt_s = 1'b0;
            state_nxt_s   = ST_READ;
          end else begin
            setup_cnt_nxt_s = setup_cnt_r + SETUP_ONE;
          end
        end
        ST_READ: begin
          if (scl_fall_s) begin
            if (byte_full_r) begin
              sda_low_nxt_s   = 1'b0;
              byte_full_nxt_s = 1'b0;
              state_nxt_s     = ST_READ_ACK;
            end else begin
              shift_nxt_s   = {shift_r[6:0], 1'b0};
              sda_low_nxt_s = ~shift_r[6];
            end
          end else begin
            state_nxt_s = ST_READ;
          end
        end
        ST_READ_ACK: begin
          if (scl_rise_s && sda_s) begin
            nack_nxt_s  = 1'b1;
            state_nxt_s = ST_WAIT_STOP;
          end else if (scl_fall_s) begin
            state_nxt_s   = ST_READ_LOAD;
            scl_low_nxt_s = 1'b1;
            dreq_nxt_s    = 1'b1;
          end else begin
            state_nxt_s = ST_READ_ACK;
          end
        end
        ST_WAIT_STOP: begin
          sda_low_nxt_s = 1'b0;
          scl_low_nxt_s = 1'b0;
        end
        default: begin
          state_nxt_s   = ST_IDLE;
          sda_low_nxt_s = 1'b0;
          scl_low_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 3'd0;
      byte_full_r <= 1'b0;
      shift_r     <= 8'h00;
      sda_low_r   <= 1'b0;
      scl_low_r   <= 1'b0;
      setup_cnt_r <= {SW{1'b0}};
      busy_r      <= 1'b0;
      addressed_r <= 1'b0;
      rnw_r       <= 1'b0;
      data_o_r    <= 8'h00;
      dav_r       <= 1'b0;
      dreq_r      <= 1'b0;
      nack_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      byte_full_r <= byte_full_nxt_s;
      shift_r     <= shift_nxt_s;
      sda_low_r   <= sda_low_nxt_s;
      scl_low_r   <= scl_low_nxt_s;
      setup_cnt_r <= setup_cnt_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      addressed_r <= addressed_nxt_s;
      rnw_r       <= rnw_nxt_s;
      data_o_r    <= data_o_nxt_s;
      dav_r       <= dav_nxt_s;
      dreq_r      <= dreq_nxt_s;
      nack_r      <= nack_nxt_s;
    end
  end

  assign busy           = busy_r;
  assign addressed      = addressed_r;
  assign read_nwrite    = rnw_r;
  assign data_o         = data_o_r;
  assign data_available = dav_r;
  assign data_request   = dreq_r;
  assign master_nack    = nack_r;

  assign SCL = scl_low_r ? 1'b0 : 1'bz;
  assign SDA = sda_low_r ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_target_sync.sv
// tb_i2c_target_sync: directed bench; a bit-level I2C master drives the pins and
// each scenario task checks bus values and user-side outputs against hand values.
module tb_i2c_target_sync;

  localparam int Q     = 5;
  localparam int SETUP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [6:0] addr;
  logic       busy, addressed, read_nwrite, data_available, data_request, master_nack;
  logic [7:0] data_o, data_i;
  logic       data_valid;
  logic       m_scl_low, m_sda_low;
  wire        scl, sda;

  pullup (scl);
  pullup (sda);
  assign scl = m_scl_low ? 1'b0 : 1'bz;
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_target_sync #(.SYNC_STAGES(2), .SETUP_CYC(SETUP)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .busy(busy), .addressed(addressed),
    .read_nwrite(read_nwrite), .data_o(data_o), .data_available(data_available),
    .data_request(data_request), .data_i(data_i), .data_valid(data_valid),
    .master_nack(master_nack), .SCL(scl), .SDA(sda)
  );

  int checks = 0;
  int failures = 0;
  int dav_cnt = 0;
  int nack_cnt = 0;
  int dut_sda_cnt = 0;
  int dreq_cnt = 0;
  logic [7:0] dav_last = 8'h00;

  // Event monitors: pulse counts and target-side SDA pulls
  always @(posedge clk) begin
    if (data_available === 1'b1) begin
      dav_cnt  <= dav_cnt + 1;
      dav_last <= data_o;
    end
    if (master_nack === 1'b1) nack_cnt <= nack_cnt + 1;
    if (data_request === 1'b1) dreq_cnt <= dreq_cnt + 1;
    if (sda === 1'b0 && !m_sda_low) dut_sda_cnt <= dut_sda_cnt + 1;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "simulation time limit");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int t = 0;
    while (scl !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (scl !== 1'b1) begin
      failures++;
      $display("FAIL scl_release_timeout scl=%b expected 1", scl);
    end
  endtask

  task automatic wait_dreq(input string name);
    int t = 0;
    while (data_request !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (data_request !== 1'b1) begin
      failures++;
      $display("FAIL %s data_request=%b expected 1", name, data_request);
    end
  endtask

  task automatic clock_bit(input logic b, output logic s);
    m_sda_low = ~b;
    tick(Q);
    m_scl_low = 1'b0;
    wait_scl_high();
    tick(Q);
    s = sda;
    tick(Q);
    m_scl_low = 1'b1;
    tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] v, input logic ack_bit);
    logic s;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      v = {v[6:0], s};
    end
    clock_bit(ack_bit, s);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0;
    tick(Q);
    m_scl_low = 1'b0;
    wait_scl_high();
    tick(Q);
    m_sda_low = 1'b1;
    tick(Q);
    m_scl_low = 1'b1;
    tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1;
    tick(Q);
    m_scl_low = 1'b0;
    wait_scl_high();
    tick(Q);
    m_sda_low = 1'b0;
    tick(Q);
  endtask

  task automatic supply(input logic [7:0] d);
    wait_dreq("supply_wait");
    data_i = d;
    data_valid = 1'b1;
    tick(1);
    data_valid = 1'b0;
    data_i = 8'h00;
  endtask

  task automatic finish_read();
    logic [7:0] v;
    supply(8'hFF);
    read_byte(v, 1'b1);
    i2c_stop();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++;
    if ({busy, addressed, read_nwrite, data_available, data_request, master_nack, data_o} !== 14'h0000) begin
      failures++;
      $display("FAIL reset_outputs got=%h expected 0000", {busy, addressed, read_nwrite, data_available, data_request, master_nack, data_o});
    end
    checks++;
    if ({scl, sda} !== 2'b11) begin
      failures++;
      $display("FAIL reset_lines scl_sda=%b expected 11", {scl, sda});
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_write();
    logic ack;
    int d0 = dav_cnt;
    i2c_start();
    send_byte(8'hA4, ack);
    checks++;
    if ({ack, addressed, read_nwrite} !== 3'b010) begin
      failures++;
      $display("FAIL write_addr ack_addr_rnw=%b expected 010", {ack, addressed, read_nwrite});
    end
    send_byte(8'hA5, ack);
    checks++;
    if (ack !== 1'b0 || dav_cnt != d0 + 1 || dav_last !== 8'hA5) begin
      failures++;
      $display("FAIL write_byte1 ack=%b pulses=%0d data=%h expected 0 %0d a5", ack, dav_cnt - d0, dav_last, 1);
    end
    send_byte(8'h3C, ack);
    checks++;
    if (ack !== 1'b0 || dav_cnt != d0 + 2 || dav_last !== 8'h3C) begin
      failures++;
      $display("FAIL write_byte2 ack=%b pulses=%0d data=%h expected 0 %0d 3c", ack, dav_cnt - d0, dav_last, 2);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL write_busy_before_stop busy=%b expected 1", busy);
    end
    i2c_stop();
    checks++;
    if ({busy, addressed} !== 2'b00 || data_o !== 8'h3C) begin
      failures++;
      $display("FAIL write_after_stop busy_addr=%b data_o=%h expected 00 3c", {busy, addressed}, data_o);
    end
  endtask

  task automatic test_addr_mismatch();
    logic ack;
    int s0 = dut_sda_cnt;
    int r0 = dreq_cnt;
    i2c_start();
    send_byte(8'hA6, ack);
    checks++;
    if ({ack, busy, addressed} !== 3'b110) begin
      failures++;
      $display("FAIL mismatch_state ack_busy_addr=%b expected 110", {ack, busy, addressed});
    end
    send_byte(8'h00, ack);
    i2c_stop();
    checks++;
    if (dut_sda_cnt != s0 || dreq_cnt != r0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mismatch_quiet sda_pulls=%0d dreq_cycles=%0d busy=%b expected 0 0 0", dut_sda_cnt - s0, dreq_cnt - r0, busy);
    end
  endtask

  task automatic test_read_stretch();
    logic ack;
    logic [7:0] v;
    i2c_start();
    send_byte(8'hA5, ack);
    checks++;
    if ({ack, addressed, read_nwrite} !== 3'b011) begin
      failures++;
      $display("FAIL read_addr ack_addr_rnw=%b expected 011", {ack, addressed, read_nwrite});
    end
    wait_dreq("read_first_request");
    m_scl_low = 1'b0;
    tick(49);
    checks++;
    if (scl !== 1'b0) begin
      failures++;
      $display("FAIL stretch_hold scl=%b expected 0", scl);
    end
    tick(1);
    data_i = 8'hC3;
    data_valid = 1'b1;
    tick(1);
    data_valid = 1'b0;
    data_i = 8'h00;
    tick(SETUP - 1);
    checks++;
    if ({scl, sda} !== 2'b01) begin
      failures++;
      $display("FAIL stretch_setup scl_sda=%b expected 01", {scl, sda});
    end
    tick(1);
    checks++;
    if (scl !== 1'b1) begin
      failures++;
      $display("FAIL stretch_release scl=%b expected 1", scl);
    end
    read_byte(v, 1'b0);
    checks++;
    if (v !== 8'hC3) begin
      failures++;
      $display("FAIL read_data got=%h expected c3", v);
    end
    wait_dreq("read_second_request");
    finish_read();
  endtask

  task automatic test_read_nack();
    logic ack;
    logic [7:0] v;
    int n0 = nack_cnt;
    i2c_start();
    send_byte(8'hA5, ack);
    supply(8'h81);
    read_byte(v, 1'b1);
    tick(2);
    checks++;
    if (v !== 8'h81 || nack_cnt != n0 + 1) begin
      failures++;
      $display("FAIL nack_byte data=%h nack_pulses=%0d expected 81 1", v, nack_cnt - n0);
    end
    checks++;
    if ({sda, busy, data_request} !== 3'b110) begin
      failures++;
      $display("FAIL nack_wait sda_busy_dreq=%b expected 110", {sda, busy, data_request});
    end
    i2c_stop();
    checks++;
    if (busy !== 1'b0 || nack_cnt != n0 + 1) begin
      failures++;
      $display("FAIL nack_stop busy=%b nack_pulses=%0d expected 0 1", busy, nack_cnt - n0);
    end
  endtask

  task automatic test_repeated_start();
    logic ack, s;
    int d0 = dav_cnt;
    i2c_start();
    send_byte(8'hA4, ack);
    clock_bit(1'b1, s);
    clock_bit(1'b0, s);
    clock_bit(1'b1, s);
    i2c_start();
    checks++;
    if ({busy, addressed} !== 2'b10) begin
      failures++;
      $display("FAIL rstart_state busy_addr=%b expected 10", {busy, addressed});
    end
    send_byte(8'hA5, ack);
    checks++;
    if ({ack, addressed, read_nwrite} !== 3'b011 || dav_cnt != d0) begin
      failures++;
      $display("FAIL rstart_read ack_addr_rnw=%b pulses=%0d expected 011 0", {ack, addressed, read_nwrite}, dav_cnt - d0);
    end
    finish_read();
  endtask

  task automatic test_reset_and_stop();
    logic ack, s;
    int d0;
    i2c_start();
    send_byte(8'hA5, ack);
    wait_dreq("reset_request");
    m_scl_low = 1'b0;
    data_i = 8'h00;
    data_valid = 1'b1;
    tick(1);
    data_valid = 1'b0;
    tick(1);
    checks++;
    if ({scl, sda} !== 2'b00) begin
      failures++;
      $display("FAIL pre_reset_lines scl_sda=%b expected 00", {scl, sda});
    end
    rst_n = 1'b0;
    tick(1);
    checks++;
    if ({scl, sda} !== 2'b11 || {busy, addressed, read_nwrite, data_available, data_request, master_nack, data_o} !== 14'h0000) begin
      failures++;
      $display("FAIL midreset lines=%b outputs=%h expected 11 0000", {scl, sda}, {busy, addressed, read_nwrite, data_available, data_request, master_nack, data_o});
    end
    rst_n = 1'b1;
    tick(3);
    d0 = dav_cnt;
    i2c_start();
    send_byte(8'hA4, ack);
    send_byte(8'h5A, ack);
    clock_bit(1'b0, s);
    clock_bit(1'b1, s);
    clock_bit(1'b1, s);
    i2c_stop();
    checks++;
    if (busy !== 1'b0 || data_o !== 8'h5A || dav_cnt != d0 + 1) begin
      failures++;
      $display("FAIL partial_stop busy=%b data_o=%h pulses=%0d expected 0 5a 1", busy, data_o, dav_cnt - d0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    addr = 7'h52;
    data_i = 8'h00;
    data_valid = 1'b0;
    m_scl_low = 1'b0;
    m_sda_low = 1'b0;
    test_reset();
    test_write();
    test_addr_mismatch();
    test_read_stretch();
    test_read_nack();
    test_repeated_start();
    test_reset_and_stop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
